// File: rtl/hdmi_pix_fetch_pkg.sv
// Shared constants and FSM encoding for the HDMI pixel prefetcher.
package hdmi_pix_fetch_pkg;

    localparam int unsigned H_ACTIVE      = 640;
    localparam int unsigned V_ACTIVE      = 480;
    localparam int unsigned FRAME_PIX_DEF = H_ACTIVE * V_ACTIVE;

    // Word base addresses of the two frame buffers in external memory.
    localparam logic [23:0] BUF0_BASE = 24'h000000;
    localparam logic [23:0] BUF1_BASE = 24'h080000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDone  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/hdmi_pix_fetch_fifo.sv
// Single-clock synchronous FIFO with flush; the read word is registered and reads as zero
// on any cycle without a pop.
module pix_fifo #(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = rdata_q;

    always_comb begin
        do_push = push_i && !full_o && !flush_i;
        do_pop  = pop_i && !empty_o && !flush_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = '0;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            // Pop reads the pre-edge head, so a same-cycle push into empty is not visible.
            if (do_pop) begin
                rptr_d  = rptr_q + PtrW'(1);
                rdata_d = mem_q[rptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/hdmi_pix_fetch.sv
// Frame pixel prefetcher: credit-limited sequential reads into a small FIFO, one RGB pixel
// out per active-video cycle.
module hdmi_pix_fetch
    import hdmi_pix_fetch_pkg::*;
#(
    parameter  int unsigned       ADDR_W     = 24,
    parameter  logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter  int unsigned       FRAME_PIX  = FRAME_PIX_DEF,
    parameter  int unsigned       FIFO_DEPTH = 16,
    localparam int unsigned       LvlW       = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned       IssW       = $clog2(FRAME_PIX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [23:0]       pix_data,
    input  logic              rd_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data_valid,
    input  logic [31:0]       rd_data,
    output logic              underflow,
    output logic [LvlW-1:0]   fifo_level
);

    localparam int unsigned CredW = LvlW + 2;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [IssW-1:0]   issued_q, issued_d;
    logic [LvlW-1:0]   in_flight_q, in_flight_d;
    logic [LvlW-1:0]   discard_q, discard_d;
    logic              underflow_q, underflow_d;

    logic [CredW-1:0]  credit;
    logic              issue, ret_drop, ret_fresh;
    logic [LvlW-1:0]   in_flight_rem, discard_rem;
    logic              fifo_empty, fifo_full;
    logic              unused_rd_data;

    assign unused_rd_data = ^rd_data[31:24];

    always_comb begin
        credit = CredW'(fifo_level) + CredW'(in_flight_q) + CredW'(discard_q);
        issue  = (state_q == StFetch) && rd_rdy && (issued_q < IssW'(FRAME_PIX))
                 && (credit < CredW'(FIFO_DEPTH));
        // Stale words from a previous frame drain first; returns with nothing owed are dropped.
        ret_drop      = rd_data_valid && (discard_q != '0);
        ret_fresh     = rd_data_valid && (discard_q == '0) && (in_flight_q != '0);
        discard_rem   = discard_q - LvlW'(ret_drop);
        in_flight_rem = in_flight_q + LvlW'(issue) - LvlW'(ret_fresh);

        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issued_d    = issued_q;
        in_flight_d = in_flight_rem;
        discard_d   = discard_rem;
        underflow_d = underflow_q;

        if (frame_start) begin
            state_d     = StFetch;
            rd_addr_d   = BASE_ADDR;
            issued_d    = '0;
            in_flight_d = '0;
            discard_d   = discard_rem + in_flight_rem;
            underflow_d = 1'b0;
        end else begin
            if (issue) begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                issued_d  = issued_q + IssW'(1);
            end
            if (pix_req && fifo_empty) begin
                underflow_d = 1'b1;
            end
            case (state_q)
                StIdle:  state_d = StIdle;
                StFetch: state_d = (issued_q == IssW'(FRAME_PIX)) ? StDone : StFetch;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            rd_addr_q   <= BASE_ADDR;
            issued_q    <= '0;
            in_flight_q <= '0;
            discard_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issued_q    <= issued_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            underflow_q <= underflow_d;
        end
    end

    pix_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (frame_start),
        .push_i  (ret_fresh && !fifo_full),
        .wdata_i (rd_data[23:0]),
        .pop_i   (pix_req && !frame_start),
        .rdata_o (pix_data),
        .count_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign rd_en     = issue;
    assign rd_addr   = rd_addr_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_hdmi_pix_fetch.sv
// Scoreboard bench for hdmi_pix_fetch: a random-latency in-order memory, a frame-level pixel
// model feeding an expectation queue, and a negedge monitor comparing against it.
module tb_hdmi_pix_fetch;

    localparam int unsigned       AW    = 24;
    localparam logic [AW-1:0]     BASE  = 24'h000040;
    localparam int unsigned       FP    = 32;
    localparam int unsigned       DEPTH = 16;
    localparam int unsigned       LW    = $clog2(DEPTH) + 1;

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic          frame_start   = 1'b0;
    logic          pix_req       = 1'b0;
    logic          rd_rdy        = 1'b0;
    logic          rd_data_valid = 1'b0;
    logic [31:0]   rd_data       = '0;
    logic [23:0]   pix_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          underflow;
    logic [LW-1:0] fifo_level;

    hdmi_pix_fetch #(
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .FRAME_PIX  (FP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .pix_req       (pix_req),
        .pix_data      (pix_data),
        .rd_rdy        (rd_rdy),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .underflow     (underflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outstanding memory requests; stale = belongs to an abandoned frame, orphan = issued
    // before a reset so the DUT no longer accounts for it.
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        bit            stale;
        bit            orphan;
    } req_t;

    typedef struct {
        logic [23:0]   pix;
        logic          uf;
        logic [LW-1:0] lvl;
    } exp_t;

    req_t pipe[$];
    exp_t expq[$];

    int cyc = 0;
    int last_due = 0;
    int lat_min = 8;
    int lat_max = 8;
    int avail = 0;
    int popped = 0;
    int issued_m = 0;
    int rd_en_cnt = 0;
    bit fetching = 0;
    bit uf_m = 0;

    // Request capture, issue-rule check and output monitor.
    int   nonorph;
    bit   exp_en;
    int   due;
    exp_t mon_e;
    always @(negedge clk) begin
        nonorph = 0;
        foreach (pipe[i]) if (!pipe[i].orphan) nonorph++;
        if (reset) begin
            exp_en = fetching && rd_rdy && (issued_m < FP) && ((avail + nonorph) < DEPTH);
            check("rd_en", 32'(rd_en), 32'(exp_en));
        end
        if (rd_en) begin
            rd_en_cnt++;
            if (reset) check("rd_addr", 32'(rd_addr), 32'(BASE + AW'(issued_m)));
            issued_m++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pipe.push_back('{rd_addr, due, 1'b0, !reset});
        end
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("pix_data", 32'(pix_data), 32'(mon_e.pix));
            check("underflow", 32'(underflow), 32'(mon_e.uf));
            check("fifo_level", 32'(fifo_level), 32'(mon_e.lvl));
        end
    end

    // Frame-level reference: pixel k of a frame is the word at BASE+k, popped in order.
    req_t ret_r;
    bit   was_fresh;
    exp_t mod_e;
    int   avail_pre;
    always @(posedge clk) begin
        cyc++;
        was_fresh = 1'b0;
        if (rd_data_valid && pipe.size() > 0) begin
            ret_r = pipe.pop_front();
            was_fresh = !ret_r.stale && !ret_r.orphan;
        end
        mod_e = '{24'h0, 1'b0, '0};
        if (!reset) begin
            foreach (pipe[i]) pipe[i].orphan = 1'b1;
            fetching = 0; avail = 0; popped = 0; issued_m = 0; uf_m = 0;
        end else if (frame_start) begin
            foreach (pipe[i]) pipe[i].stale = 1'b1;
            fetching = 1; avail = 0; popped = 0; issued_m = 0; uf_m = 0;
        end else begin
            avail_pre = avail;
            if (pix_req) begin
                if (avail_pre > 0) begin
                    mod_e.pix = 24'(BASE) + 24'(popped);
                    popped++;
                    avail--;
                end else begin
                    uf_m = 1;
                end
            end
            if (was_fresh) begin
                check("return_not_full", 32'(avail_pre < DEPTH), 32'd1);
                avail++;
            end
        end
        mod_e.uf  = uf_m;
        mod_e.lvl = LW'(avail);
        expq.push_back(mod_e);
        #1;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data = {8'($urandom),
                       (pipe[0].stale || pipe[0].orphan) ? 24'hBAD : 24'(pipe[0].addr)};
        end else begin
            rd_data_valid = 1'b0;
            rd_data = $urandom;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    bit done;
    initial begin
        // Reset, then idle with rd_rdy high: no reads before the first frame_start.
        rd_rdy = 1'b1;
        tick(3);
        reset = 1'b1;
        check("reset_rd_addr", 32'(rd_addr), 32'(BASE));
        tick(10);

        // Fill with no consumer: exactly DEPTH reads, FIFO settles full.
        rd_en_cnt = 0;
        pulse_frame();
        tick(60);
        check("fill_rd_en_count", 32'(rd_en_cnt), 32'(DEPTH));
        check("fill_level", 32'(fifo_level), 32'(DEPTH));

        // Drain the whole frame in order, then the fetcher stays quiet.
        pix_req = 1'b1;
        tick(FP);
        pix_req = 1'b0;
        tick(30);
        check("frame_rd_en_count", 32'(rd_en_cnt), 32'(FP));
        check("frame_no_underflow", 32'(underflow), 32'd0);

        // Underflow with nothing fetched; cleared by the next frame_start.
        rd_rdy = 1'b0;
        pulse_frame();
        tick(3);
        pix_req = 1'b1;
        tick(3);
        pix_req = 1'b0;
        tick(1);
        check("underflow_set", 32'(underflow), 32'd1);
        pulse_frame();
        check("underflow_clear", 32'(underflow), 32'd0);

        // Restart with reads in flight: stale words (tagged BAD) must never surface.
        lat_min = 10; lat_max = 10;
        rd_rdy = 1'b1;
        pulse_frame();
        tick(5);
        pulse_frame();
        tick(40);
        pix_req = 1'b1;
        tick(16);
        pix_req = 1'b0;
        tick(3);

        // Reset mid-fetch with reads outstanding; late returns must be ignored.
        pulse_frame();
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'(BASE));
        tick(25);

        // Random ready/latency/consumer over two frames; second start collides with pix_req.
        lat_min = 2; lat_max = 12;
        for (int f = 0; f < 2; f++) begin
            pix_req = (f == 1);
            pulse_frame();
            done = 0;
            for (int c = 0; c < 3000 && !done; c++) begin
                rd_rdy  = 1'($urandom_range(1, 0));
                pix_req = ($urandom_range(3, 0) != 0);
                tick(1);
                if (popped >= FP) done = 1;
            end
            pix_req = 1'b0;
            check("random_frame_complete", 32'(done), 32'd1);
            tick(2);
        end

        rd_rdy = 1'b0;
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
